// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider with IDLE/RUN/DONE control.
// One quotient bit is produced per clock, MSB first; divide-by-zero finishes
// after a single clock. Define SEQ_DIVIDER_SIGNED_EN to add the sgn input and
// two's complement operation (magnitude divide plus sign fix-up).
module seq_divider #(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic         sgn,
`endif
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] q,
    output logic [n-1:0] r,
    output logic         dz
);

    localparam int unsigned W  = n + 1;
    localparam int unsigned CW = $clog2(n);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [n-1:0]    rem_q,   rem_d;
    logic [n-1:0]    dvd_q,   dvd_d;
    logic [n-1:0]    dvs_q,   dvs_d;
    logic [n-1:0]    q_q,     q_d;
    logic [n-1:0]    r_q,     r_d;
    logic            dz_q,    dz_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [n:0]      shift_w;
    logic [n:0]      trial_w;
    logic            qbit_w;
    logic [n-1:0]    rem_nx;
    logic [n-1:0]    dvd_nx;
    logic [n-1:0]    a_mag;
    logic [n-1:0]    b_mag;
    logic [n-1:0]    q_fin;
    logic [n-1:0]    r_fin;

    // One restoring step: shift in next dividend bit, subtract divisor via add of ~{0,b}+1.
    assign shift_w = {rem_q, dvd_q[n-1]};
    assign trial_w = shift_w + ~{1'b0, dvs_q} + W'(1);
    assign qbit_w  = ~trial_w[n];
    assign rem_nx  = qbit_w ? trial_w[n-1:0] : shift_w[n-1:0];
    assign dvd_nx  = {dvd_q[n-2:0], qbit_w};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;

    // Divide magnitudes; most-negative magnitude is still correct read as unsigned.
    assign a_mag = (sgn && a[n-1]) ? -a : a;
    assign b_mag = (sgn && b[n-1]) ? -b : b;
    assign q_fin = q_neg_q ? -dvd_nx : dvd_nx;
    assign r_fin = r_neg_q ? -rem_nx : rem_nx;
`else
    assign a_mag = a;
    assign b_mag = b;
    assign q_fin = dvd_nx;
    assign r_fin = rem_nx;
`endif

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = a_mag;
                    dvs_d = b_mag;
                    rem_d = '0;
                    cnt_d = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    q_neg_d = sgn & (a[n-1] ^ b[n-1]);
                    r_neg_d = sgn & a[n-1];
`endif
                    if (b == '0) begin
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = a;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        dz_d    = 1'b0;
                    end
                end
            end
            RUN: begin
                rem_d = rem_nx;
                dvd_d = dvd_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(n - 1)) begin
                    state_d = DONE;
                    q_d     = q_fin;
                    r_d     = r_fin;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;

endmodule
